ber_checker: RTL
================

# ber_checker

Receive-side PRBS9 bit-error-rate checker. It sits after the matched-filter receiver (`rx`) at the far end of the `prbs` → `tx` → `rx` chain. It self-synchronises to the recovered bit stream, predicts each next bit from the PRBS9 recurrence, and counts compared bits and errors. Loss of lock triggers an automatic resync.

## Interface
Parameters:
- `LOCK_CNT`, 32: consecutive correct predictions required to declare lock.
- `WIN`, 128: error-monitoring window length in checked bits; range 2..65535.
- `ERR_THR`, 8: errors within one window above which lock is lost.
- `CNT_W`, 32: width of the bit and error counters.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-low.
- `enable` in 1: one-cycle symbol strobe; `rx_in` is valid only on this cycle.
- `rx_in` in 1: recovered bit from `rx`.
- `clear` in 1: synchronous counter clear.
- `locked` out 1: checker is in LOCK.
- `err_flag` out 1: one-cycle pulse, the last checked bit mismatched.
- `bit_count` out CNT_W: bits compared while locked (saturating).
- `err_count` out CNT_W: mismatches while locked (saturating).

## Operation
- Recurrence, matching `prbs`: b[n] = b[n-9] ^ b[n-5].
- Internal history register `h[8:0]`:
  - h[0] is the newest bit.
  - Prediction e = h[8] ^ h[4].
  - On each `enable`, shift left and insert a bit at h[0].
- Nothing changes on cycles without `enable`, except the effect of `clear`.

State machine FILL → SYNC → LOCK:
- **FILL**: shift `rx_in` into h. After the 9th `enable`, go to SYNC. Fill counter 0..8.
- **SYNC**: shift `rx_in` into h (received bits, not predictions).
  - If `rx_in` == e, increment the match counter.
  - Otherwise, reset the match counter to 0.
  - When the match counter reaches `LOCK_CNT`, go to LOCK; the match counter clears.
  - No counting and no `err_flag` in this state.
- **LOCK**: shift e into h, so received errors do not propagate.
  - On each `enable`: `bit_count` += 1.
  - If `rx_in` != e: `err_count` += 1 and `err_flag` = 1 for one cycle.
  - Window counter counts 0..WIN-1; a window error counter tracks errors in the current window.
  - At the end of a window (the WIN-th bit, including that bit's error), compare the window errors against `ERR_THR`:
    - If window errors > `ERR_THR`: go to FILL and clear h.
    - Otherwise: restart the window and zero the window error counter.
- Counters saturate at 2^CNT_W−1.
- `clear`:
  - Zeroes `bit_count` and `err_count` next cycle.
  - Has priority over a coincident increment; that bit is not counted.
  - Does not affect the state, h, or the window counters.

## Timing
- All outputs are registered.
- Reset values: state FILL; h = 0; all internal counters 0; `locked` = 0; `err_flag` = 0; `bit_count` = 0; `err_count` = 0.
- Latency: the cycle after the sampling `enable` edge, all of the following are valid:
  - `err_flag`
  - `bit_count`
  - `err_count`
  - `locked` changes
- Minimum lock time from reset on a clean stream: 9 + `LOCK_CNT` enables. `locked` rises the cycle after the last of these.
- Back-to-back `enable` (every cycle) must be supported.
- `rst` asserted mid-operation: all state returns to reset values immediately; lock must be re-acquired.

## Configuration
- `BER_RESYNC_EN` defined: window monitoring active, and LOCK → FILL occurs as described above.
- `BER_RESYNC_EN` not defined:
  - Window counters are not built.
  - LOCK is held until `rst`.
  - Counting continues indefinitely.

## Structure
- Package `ber_pkg`:
  - PRBS9 length constant 9 and tap index constants 8 and 4.
  - State encoding FILL/SYNC/LOCK.
  - Default `CNT_W`.
- Sub-module `ber_predictor`: the 9-bit history register plus prediction.
  - Inputs: `enable`, load-select (received vs predicted bit), `rx_in`, sync clear.
  - Output: e.
- The top level contains the FSM and the counters.

## Test plan
- Clean lock and run:
  - Stimulus: `prbs` (SEED 9'h1AA) drives `rx_in` with `enable` every 4th cycle.
  - Response: `locked` rises after 41 enables; after 500 locked bits, `bit_count` = 500 and `err_count` = 0.
- Single error:
  - Stimulus: flip one bit after lock.
  - Response: `err_flag` pulses exactly once; `err_count` = 1; `locked` stays 1.
- Inverted stream:
  - Stimulus: invert every bit after lock, with `BER_RESYNC_EN` defined.
  - Response: every bit errs; `locked` falls at the first window boundary (≤128 bits); relock occurs ≤41 enables after inversion stops.
- Resync disabled:
  - Stimulus: same inverted stream without `BER_RESYNC_EN`.
  - Response: `locked` stays 1; `err_count` increments by one per bit.
- Saturation and clear:
  - Stimulus: `CNT_W` = 8; 300 locked bits; then `clear` pulsed coincident with an error bit.
  - Response: `bit_count` = 255 after 300 bits; after `clear`, `bit_count` = 0 and `err_count` = 0, with `locked` unchanged.
- Reset mid-lock:
  - Stimulus: assert `rst` for 1 cycle while locked.
  - Response: all outputs 0 immediately; relock after 41 enables.

Source files
------------

// File: rtl/ber_pkg.sv
// ---------------------------------------------------------------------------
// ber_pkg
// Shared definitions for the PRBS9 bit-error-rate checker.
//   PRBS_LEN      : length of the PRBS9 history (9 bits)
//   TAP_HI/TAP_LO : history taps feeding the prediction, b[n-9] ^ b[n-5]
//   DEFAULT_CNT_W : default width of the bit and error counters
//   berState_t    : checker state encoding FILL / SYNC / LOCK
// ---------------------------------------------------------------------------
package ber_pkg;

   localparam int PRBS_LEN      = 9;
   localparam int TAP_HI        = 8;
   localparam int TAP_LO        = 4;
   localparam int DEFAULT_CNT_W = 32;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_SYNC = 2'd1,
      ST_LOCK = 2'd2
   } berState_t;

endpackage

// File: rtl/ber_predictor.sv
// ---------------------------------------------------------------------------
// ber_predictor
// Nine-bit PRBS9 history register with next-bit prediction. The newest bit
// sits at bit 0; the prediction is h[8] ^ h[4]. On each enable the register
// shifts left and takes either the received bit or its own prediction.
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   i_enable : symbol strobe, shift on this cycle
//   i_loadRx : 1 = shift in i_rxIn, 0 = shift in the prediction
//   i_rxIn   : received bit
//   i_clr    : synchronous clear of the history (wins over i_enable)
//   o_pred   : predicted next bit
// ---------------------------------------------------------------------------
module ber_predictor
   import ber_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_enable,
   input  logic i_loadRx,
   input  logic i_rxIn,
   input  logic i_clr,
   output logic o_pred
);

   logic [PRBS_LEN-1:0] r_hist;
   logic                w_pred;
   logic                w_shiftIn;

   assign w_pred    = r_hist[TAP_HI] ^ r_hist[TAP_LO];
   assign w_shiftIn = i_loadRx ? i_rxIn : w_pred;
   assign o_pred    = w_pred;

   // History shift register. A clear coincident with a strobe discards
   // that strobe's bit so the next fill starts from an all-zero history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= '0;
      end else if (i_clr) begin
         r_hist <= '0;
      end else if (i_enable) begin
         r_hist <= {r_hist[PRBS_LEN-2:0], w_shiftIn};
      end
   end

endmodule

// File: rtl/ber_checker.sv
// ---------------------------------------------------------------------------
// ber_checker
// Receive-side PRBS9 bit-error-rate checker. Fills a history register from
// the recovered stream, waits for LOCK_CNT consecutive correct predictions,
// then free-runs the predictor and counts compared bits and mismatches.
// Ports:
//   clk       : system clock
//   rst       : asynchronous reset, active-low
//   enable    : one-cycle symbol strobe qualifying rx_in
//   rx_in     : recovered bit
//   clear     : synchronous clear of bit_count / err_count
//   locked    : checker is in LOCK
//   err_flag  : one-cycle pulse, last checked bit mismatched
//   bit_count : bits compared while locked (saturating)
//   err_count : mismatches while locked (saturating)
// Build option:
//   BER_RESYNC_EN : when defined, errors are monitored over windows of WIN
//                   checked bits; more than ERR_THR errors in a window drops
//                   lock and restarts the fill. When undefined, LOCK is held
//                   until reset and the window logic is not built.
// ---------------------------------------------------------------------------
module ber_checker
   import ber_pkg::*;
#(
   parameter int LOCK_CNT = 32,
   parameter int WIN      = 128,
   parameter int ERR_THR  = 8,
   parameter int CNT_W    = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             rx_in,
   input  logic             clear,
   output logic             locked,
   output logic             err_flag,
   output logic [CNT_W-1:0] bit_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);

   berState_t           r_state;
   berState_t           w_stateNext;
   logic [3:0]          r_fillCnt;
   logic [3:0]          w_fillCntNext;
   logic [MATCH_W-1:0]  r_matchCnt;
   logic [MATCH_W-1:0]  w_matchCntNext;
   logic                r_locked;
   logic                r_errFlag;
   logic [CNT_W-1:0]    r_bitCount;
   logic [CNT_W-1:0]    r_errCount;

   logic                w_pred;
   logic                w_mismatch;
   logic                w_loadRx;
   logic                w_hClr;
   logic                w_count;

`ifdef BER_RESYNC_EN
   logic [15:0]         r_winCnt;
   logic [15:0]         w_winCntNext;
   logic [15:0]         r_winErr;
   logic [15:0]         w_winErrNext;
   logic [15:0]         w_winErrSum;

   assign w_winErrSum = r_winErr + {15'd0, w_mismatch};
`endif

   assign w_mismatch = rx_in ^ w_pred;

   ber_predictor u_predictor (
      .clk      (clk),
      .rst      (rst),
      .i_enable (enable),
      .i_loadRx (w_loadRx),
      .i_rxIn   (rx_in),
      .i_clr    (w_hClr),
      .o_pred   (w_pred)
   );

   // Next-state and control decode. FILL and SYNC shift received bits so
   // the history tracks the line; LOCK shifts predictions so a corrupted
   // bit cannot poison later predictions.
   always_comb begin
      w_stateNext    = r_state;
      w_fillCntNext  = r_fillCnt;
      w_matchCntNext = r_matchCnt;
      w_loadRx       = 1'b1;
      w_hClr         = 1'b0;
      w_count        = 1'b0;
`ifdef BER_RESYNC_EN
      w_winCntNext   = r_winCnt;
      w_winErrNext   = r_winErr;
`endif
      case (r_state)
         ST_FILL: begin
            if (enable) begin
               if (r_fillCnt == 4'(PRBS_LEN - 1)) begin
                  w_fillCntNext = 4'd0;
                  w_stateNext   = ST_SYNC;
               end else begin
                  w_fillCntNext = r_fillCnt + 4'd1;
               end
            end
         end
         ST_SYNC: begin
            if (enable) begin
               if (w_mismatch) begin
                  w_matchCntNext = '0;
               end else if (r_matchCnt == MATCH_W'(LOCK_CNT - 1)) begin
                  w_matchCntNext = '0;
                  w_stateNext    = ST_LOCK;
               end else begin
                  w_matchCntNext = r_matchCnt + MATCH_W'(1);
               end
            end
         end
         ST_LOCK: begin
            w_loadRx = 1'b0;
            if (enable) begin
               w_count = 1'b1;
`ifdef BER_RESYNC_EN
               if (r_winCnt == 16'(WIN - 1)) begin
                  w_winCntNext = 16'd0;
                  w_winErrNext = 16'd0;
                  if (32'(w_winErrSum) > 32'(ERR_THR)) begin
                     w_stateNext = ST_FILL;
                     w_hClr      = 1'b1;
                  end
               end else begin
                  w_winCntNext = r_winCnt + 16'd1;
                  w_winErrNext = w_winErrSum;
               end
`endif
            end
         end
         default: begin
            w_stateNext = ST_FILL;
         end
      endcase
   end

   // State and acquisition counters. locked is registered from the next
   // state so it rises the cycle after the final matching strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_FILL;
         r_fillCnt  <= 4'd0;
         r_matchCnt <= '0;
         r_locked   <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_fillCnt  <= w_fillCntNext;
         r_matchCnt <= w_matchCntNext;
         r_locked   <= (w_stateNext == ST_LOCK);
      end
   end

`ifdef BER_RESYNC_EN
   // Error-monitoring window; only advances on strobes while locked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_winCnt <= 16'd0;
         r_winErr <= 16'd0;
      end else begin
         r_winCnt <= w_winCntNext;
         r_winErr <= w_winErrNext;
      end
   end
`endif

   // Saturating statistics counters. clear wins over a coincident count,
   // so the bit checked on that cycle is dropped from both counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_errFlag  <= 1'b0;
         r_bitCount <= '0;
         r_errCount <= '0;
      end else begin
         r_errFlag <= w_count & w_mismatch;
         if (clear) begin
            r_bitCount <= '0;
            r_errCount <= '0;
         end else if (w_count) begin
            if (r_bitCount != '1) begin
               r_bitCount <= r_bitCount + CNT_W'(1);
            end
            if (w_mismatch && (r_errCount != '1)) begin
               r_errCount <= r_errCount + CNT_W'(1);
            end
         end
      end
   end

   assign locked    = r_locked;
   assign err_flag  = r_errFlag;
   assign bit_count = r_bitCount;
   assign err_count = r_errCount;

endmodule
